servo_slew_limiter: RTL and testbench
=====================================

Name: servo_slew_limiter

Overview:
- Rate-limits and supervises the 11-bit servo pulse-width command (in µs) between the proximity-checked steering value and the steering PWM generator.
- Clamps the target to the legal servo range and ignores small jitter using a deadband.
- Walks the output toward the target by a bounded step per update tick.
- Forces the servo to centre if command updates stop arriving (SPI link loss).

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
STEP_HZ, 1000, update tick rate in Hz; DIV = CLK_HZ/STEP_HZ (integer, ≥2)
MAX_STEP, 4, maximum output change per tick, in µs
MIN_US, 1000, lower clamp of target/output
MAX_US, 2000, upper clamp of target/output
CENTER_US, 1500, reset and failsafe position
DEADBAND, 8, a new command is accepted only if |cmd − target| > DEADBAND
TIMEOUT_TICKS, 200, ticks without cmd_valid before failsafe

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  reset, synchronous and active-low (asserted when 0, sampled on rising clk)
cmd_us  input  11  requested pulse width in µs, unsigned
cmd_valid  input  1  single-cycle strobe: cmd_us is valid this cycle
pos_us  output  11  rate-limited pulse width to the PWM generator
at_target  output  1  high when pos_us == target
failsafe  output  1  high while in FAILSAFE state
tick_o  output  1  one-cycle pulse on each update tick (debug/LED use)

Behaviour:
- Reset (rst==0 at a clk edge):
  - pos_us = CENTER_US, target = CENTER_US, at_target = 1, failsafe = 0, tick_o = 0.
  - Divider and timeout counters = 0; state = IDLE.
  - Reset overrides everything, including mid-ramp.
- Tick divider:
  - Free-running counter 0..DIV−1.
  - tick_o = 1 for exactly the cycle where the counter == DIV−1, then the counter wraps to 0.
  - First tick occurs DIV cycles after reset release.
- Command capture, on a cycle with cmd_valid == 1:
  - c = clamp(cmd_us, MIN_US, MAX_US).
  - If |c − target| > DEADBAND, target ← c on the next edge; otherwise target is unchanged.
  - The timeout counter clears to 0 regardless of whether the command is accepted.
- Timeout:
  - The timeout counter increments on each tick when cmd_valid is low, saturating at TIMEOUT_TICKS.
  - On reaching TIMEOUT_TICKS: target ← CENTER_US, state → FAILSAFE.
- Stepping, on a tick:
  - d = target − pos_us (signed, 12 bits).
  - If d > 0: pos_us += min(d, MAX_STEP). If d < 0: pos_us −= min(−d, MAX_STEP).
  - The result never overshoots target and never leaves [MIN_US, MAX_US].
  - pos_us changes only on tick cycles.
- States:
  - IDLE (pos_us == target): → RAMP when target ≠ pos_us.
  - RAMP: → IDLE when a tick lands pos_us on target.
  - FAILSAFE: ramps toward CENTER_US at MAX_STEP per tick.
    - Command capture is ignored, except that any cmd_valid exits to RAMP (or IDLE if the deadband is not exceeded), clears failsafe, and applies the normal capture rule.
- at_target: registered; high exactly when pos_us == target after the edge.
- Simultaneous events:
  - cmd_valid and tick on the same cycle: the step uses the old target; the new target is registered on the same edge.
  - cmd_valid on the same tick the timeout would expire: cmd_valid wins, counter → 0, no failsafe.
  - cmd_us = 0 or 2047: clamped to MIN_US/MAX_US before the deadband check.
- Latency:
  - cmd_valid to target update: 1 cycle.
  - Target to first pos_us movement: next tick.

Test Plan (bench uses CLK_HZ=1000, STEP_HZ=100 → DIV=10; MAX_STEP=4, DEADBAND=8, TIMEOUT_TICKS=5):
- Reset: hold rst=0 for 3 cycles, release -> pos_us=1500, at_target=1, failsafe=0; first tick_o exactly 10 cycles after release, then every 10 cycles.
- Ramp up: cmd_us=1510 strobed once -> pos_us 1504, 1508, 1510 on the next three ticks; at_target=1 after the third tick; no overshoot.
- Deadband and clamp: at pos 1500, cmd_us=1506 -> no change; cmd_us=2047 -> target 2000, pos_us rises by 4 per tick up to 2000; cmd_us=0 -> ramps down to 1000.
- Timeout: target 1600, then no cmd_valid for 5 ticks -> failsafe=1, pos_us ramps 4/tick to 1500. A following cmd_us=1700 -> failsafe=0, ramps to 1700.
- Simultaneous: cmd_valid (1700) asserted on a tick cycle while pos=1500, target=1500 -> pos stays 1500 that tick and moves to 1504 on the next tick. cmd_valid on the 5th idle tick -> no failsafe.
- Reset mid-ramp: during a ramp 1000→2000 at pos 1240, rst=0 for 1 cycle -> pos_us=1500, target=1500, counters 0 on the next edge.

Source files
------------

// File: rtl/servo_slew_limiter.sv
// Rate limiter and link-loss supervisor for the steering servo pulse width.
// Clamps and deadbands commands, walks the output by a bounded step per tick, centres on timeout.
module servo_slew_limiter #(
    parameter int CLK_HZ        = 100000000,
    parameter int STEP_HZ       = 1000,
    parameter int MAX_STEP      = 4,
    parameter int MIN_US        = 1000,
    parameter int MAX_US        = 2000,
    parameter int CENTER_US     = 1500,
    parameter int DEADBAND      = 8,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] cmd_us,
    input  logic        cmd_valid,
    output logic [10:0] pos_us,
    output logic        at_target,
    output logic        failsafe,
    output logic        tick_o
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [10:0]        MIN_L    = 11'(MIN_US);
    localparam logic [10:0]        MAX_L    = 11'(MAX_US);
    localparam logic [10:0]        CENTER_L = 11'(CENTER_US);
    localparam logic signed [11:0] STEP_P   = 12'(MAX_STEP);
    localparam logic signed [11:0] STEP_N   = 12'(-MAX_STEP);
    localparam logic signed [11:0] DB_P     = 12'(DEADBAND);
    localparam logic signed [11:0] DB_N     = 12'(-DEADBAND);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_PRE  = DIV_W'(DIV - 2);
    localparam logic [TO_W-1:0]    TO_MAX   = TO_W'(TIMEOUT_TICKS);
    localparam logic [TO_W-1:0]    TO_PRE   = TO_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   div_next_s;
    logic               tick_r;
    logic               tick_s;
    logic [TO_W-1:0]    to_r;
    logic [TO_W-1:0]    to_next_s;
    logic [10:0]        target_r;
    logic [10:0]        target_next_s;
    logic [10:0]        pos_r;
    logic [10:0]        pos_next_s;
    logic               at_target_r;
    logic               failsafe_r;
    logic [10:0]        cmd_clamp_s;
    logic signed [11:0] cap_diff_s;
    logic signed [11:0] diff_s;
    logic signed [11:0] step_s;
    logic               accept_s;
    logic               expire_s;
    logic               landed_s;

    // Datapath: divider, command capture, timeout and bounded step toward the current target.
    always_comb begin
        tick_s     = (div_r == DIV_LAST);
        div_next_s = tick_s ? '0 : div_r + DIV_W'(1);

        if (cmd_us < MIN_L) begin
            cmd_clamp_s = MIN_L;
        end else if (cmd_us > MAX_L) begin
            cmd_clamp_s = MAX_L;
        end else begin
            cmd_clamp_s = cmd_us;
        end

        cap_diff_s = $signed({1'b0, cmd_clamp_s}) - $signed({1'b0, target_r});
        accept_s   = cmd_valid && ((cap_diff_s > DB_P) || (cap_diff_s < DB_N));
        expire_s   = tick_s && !cmd_valid && (to_r == TO_PRE);

        // The step always uses the pre-edge target, so a same-cycle command moves pos_us a tick later.
        diff_s = $signed({1'b0, target_r}) - $signed({1'b0, pos_r});
        if (diff_s > STEP_P) begin
            step_s = STEP_P;
        end else if (diff_s < STEP_N) begin
            step_s = STEP_N;
        end else begin
            step_s = diff_s;
        end
        pos_next_s = tick_s ? 11'($signed({1'b0, pos_r}) + step_s) : pos_r;

        if (cmd_valid) begin
            to_next_s = '0;
        end else if (tick_s && (to_r != TO_MAX)) begin
            to_next_s = to_r + TO_W'(1);
        end else begin
            to_next_s = to_r;
        end

        if (accept_s) begin
            target_next_s = cmd_clamp_s;
        end else if (expire_s) begin
            target_next_s = CENTER_L;
        end else begin
            target_next_s = target_r;
        end

        landed_s = (pos_next_s == target_next_s);
    end

    // Next-state logic: link loss forces FAILSAFE, any command leaves it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_RAMP: begin
                if (expire_s) begin
                    state_next_s = ST_FAILSAFE;
                end else if (landed_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RAMP;
                end
            end
            ST_FAILSAFE: begin
                if (!cmd_valid) begin
                    state_next_s = ST_FAILSAFE;
                end else if (landed_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RAMP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            div_r       <= '0;
            tick_r      <= 1'b0;
            to_r        <= '0;
            target_r    <= CENTER_L;
            pos_r       <= CENTER_L;
            at_target_r <= 1'b1;
            failsafe_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            div_r       <= div_next_s;
            tick_r      <= (div_r == DIV_PRE);
            to_r        <= to_next_s;
            target_r    <= target_next_s;
            pos_r       <= pos_next_s;
            at_target_r <= landed_s;
            failsafe_r  <= (state_next_s == ST_FAILSAFE);
        end
    end

    assign pos_us    = pos_r;
    assign at_target = at_target_r;
    assign failsafe  = failsafe_r;
    assign tick_o    = tick_r;

endmodule

// File: tb/tb_servo_slew_limiter.sv
// Randomized and directed bench for servo_slew_limiter against a cycle-level behavioural model.
module tb_servo_slew_limiter;

    localparam int DIV     = 10;
    localparam int STEP    = 4;
    localparam int DB      = 8;
    localparam int TMO     = 5;
    localparam int LO      = 1000;
    localparam int HI      = 2000;
    localparam int CENTRE  = 1500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] cmd_us = 11'd0;
    logic        cmd_valid = 1'b0;
    logic [10:0] pos_us;
    logic        at_target;
    logic        failsafe;
    logic        tick_o;

    int checks = 0;
    int errors = 0;

    // model state: position, target, idle ticks, failsafe flag, clock edges since reset
    int m_pos = CENTRE;
    int m_tgt = CENTRE;
    int m_to  = 0;
    int m_fs  = 0;
    int m_cyc = 0;

    servo_slew_limiter #(
        .CLK_HZ(1000), .STEP_HZ(100), .MAX_STEP(STEP), .MIN_US(LO), .MAX_US(HI),
        .CENTER_US(CENTRE), .DEADBAND(DB), .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .cmd_us(cmd_us), .cmd_valid(cmd_valid),
        .pos_us(pos_us), .at_target(at_target), .failsafe(failsafe), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, m_cyc);
        end
    endtask

    function automatic int clampi(input int v);
        return (v < LO) ? LO : ((v > HI) ? HI : v);
    endfunction

    task automatic model_edge(input logic r, input logic v, input int c);
        int d;
        int cc;
        bit tick;
        if (!r) begin
            m_pos = CENTRE; m_tgt = CENTRE; m_to = 0; m_fs = 0; m_cyc = 0;
        end else begin
            tick = ((m_cyc % DIV) == DIV - 1);
            if (tick) begin
                d = m_tgt - m_pos;
                if (d > STEP) d = STEP;
                if (d < -STEP) d = -STEP;
                m_pos = m_pos + d;
            end
            if (v) begin
                cc = clampi(c);
                if (cc - m_tgt > DB || m_tgt - cc > DB) m_tgt = cc;
                m_to = 0;
                m_fs = 0;
            end else if (tick) begin
                if (m_to == TMO - 1) begin
                    m_to = TMO; m_fs = 1; m_tgt = CENTRE;
                end else if (m_to < TMO) begin
                    m_to++;
                end
            end
            m_cyc++;
        end
    endtask

    task automatic cyc(input logic r, input logic v, input int c);
        @(negedge clk);
        rst = r;
        cmd_valid = v;
        cmd_us = 11'(c);
        model_edge(r, v, c);
        @(posedge clk);
        #1;
        check_eq("pos_us", int'(pos_us), m_pos);
        check_eq("at_target", int'(at_target), int'(m_pos == m_tgt));
        check_eq("failsafe", int'(failsafe), m_fs);
        check_eq("tick_o", int'(tick_o), int'((m_cyc % DIV) == DIV - 1));
    endtask

    // one optional strobe, then idle until the next step has been applied
    task automatic tick_with(input logic v, input int c);
        cyc(1'b1, v, c);
        while ((m_cyc % DIV) != 0) cyc(1'b1, 1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
    endtask

    initial begin
        int first;
        int period;
        int ramp_exp[3];
        int guard;

        // reset values and tick cadence
        do_reset(3);
        check_eq("rst_pos", int'(pos_us), CENTRE);
        check_eq("rst_at", int'(at_target), 1);
        check_eq("rst_fs", int'(failsafe), 0);
        check_eq("rst_tick", int'(tick_o), 0);
        first = -1;
        for (int n = 1; n <= 2 * DIV; n++) begin
            cyc(1'b1, 1'b0, 0);
            if (tick_o) begin first = n; break; end
        end
        check_eq("first_tick_edge", first, DIV - 1);
        period = -1;
        for (int n = 1; n <= 2 * DIV; n++) begin
            cyc(1'b1, 1'b0, 0);
            if (tick_o) begin period = n; break; end
        end
        check_eq("tick_period", period, DIV);

        // ramp up by bounded steps without overshoot
        ramp_exp[0] = 1504; ramp_exp[1] = 1508; ramp_exp[2] = 1510;
        do_reset(1);
        for (int k = 0; k < 3; k++) begin
            tick_with(k == 0, 1510);
            check_eq("ramp_pos", int'(pos_us), ramp_exp[k]);
        end
        check_eq("ramp_at", int'(at_target), 1);

        // deadband, then clamped extremes
        do_reset(1);
        tick_with(1'b1, 1506);
        check_eq("deadband_pos", int'(pos_us), CENTRE);
        for (int k = 0; k < 130; k++) tick_with(1'b1, 2047);
        check_eq("clamp_hi", int'(pos_us), HI);
        for (int k = 0; k < 260; k++) tick_with(1'b1, 0);
        check_eq("clamp_lo", int'(pos_us), LO);

        // link loss: failsafe and return to centre, then recovery
        tick_with(1'b1, 1600);
        for (int k = 0; k < TMO - 1; k++) tick_with(1'b0, 0);
        check_eq("timeout_fs", int'(failsafe), 1);
        for (int k = 0; k < 130; k++) tick_with(1'b0, 0);
        check_eq("fs_centre", int'(pos_us), CENTRE);
        cyc(1'b1, 1'b1, 1700);
        check_eq("fs_exit", int'(failsafe), 0);
        for (int k = 0; k < 60; k++) tick_with(1'b1, 1700);
        check_eq("fs_recover", int'(pos_us), 1700);

        // command on a tick cycle steps with the old target
        do_reset(1);
        while ((m_cyc % DIV) != DIV - 1) cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, 1700);
        check_eq("simul_hold", int'(pos_us), CENTRE);
        tick_with(1'b0, 0);
        check_eq("simul_step", int'(pos_us), 1504);

        // command on the expiring tick keeps failsafe off
        do_reset(1);
        for (int k = 0; k < TMO - 1; k++) tick_with(1'b0, 0);
        while ((m_cyc % DIV) != DIV - 1) cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b1, CENTRE);
        check_eq("expire_race", int'(failsafe), 0);
        tick_with(1'b0, 0);
        check_eq("expire_race2", int'(failsafe), 0);

        // reset in the middle of a ramp
        do_reset(1);
        for (int k = 0; k < 130; k++) tick_with(1'b1, 0);
        guard = 0;
        while (m_pos != 1240 && guard < 200) begin
            tick_with(1'b1, 2000);
            guard++;
        end
        check_eq("midramp_reached", m_pos, 1240);
        check_eq("midramp_dut", int'(pos_us), 1240);
        cyc(1'b0, 1'b0, 0);
        check_eq("midramp_rst_pos", int'(pos_us), CENTRE);
        check_eq("midramp_rst_at", int'(at_target), 1);
        first = -1;
        for (int n = 1; n <= 2 * DIV; n++) begin
            cyc(1'b1, 1'b0, 0);
            if (tick_o) begin first = n; break; end
        end
        check_eq("midramp_div_cleared", first, DIV - 1);

        // randomized traffic: busy and silent segments, occasional resets
        for (int seg = 0; seg < 20; seg++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < 200; i++) begin
                logic r;
                logic v;
                int c;
                r = ($urandom_range(0, 599) != 0);
                v = (mode == 0) ? ($urandom_range(0, 7) == 0) :
                    (mode == 1) ? ($urandom_range(0, 79) == 0) : 1'b0;
                if ($urandom_range(0, 1) == 0)
                    c = int'($urandom_range(0, 2047));
                else
                    c = m_tgt + int'($urandom_range(0, 32)) - 16;
                if (c < 0) c = 0;
                if (c > 2047) c = 2047;
                cyc(r, v, c);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
